// File: rtl/ph_sample_scheduler_if.sv
// Sensor-side bundle for ph_sample_scheduler: per-channel request/PH/clear in,
// grant, sample report and per-channel alarms out.
interface ph_sample_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic [N_CH-1:0]   chReq;
  logic [4*N_CH-1:0] chPH;
  logic [N_CH-1:0]   alarmClear;
  logic [N_CH-1:0]   chGrant;
  logic              sampleValid;
  logic [CH_W-1:0]   sampleCh;
  logic [3:0]        samplePH;
  logic              abnormalityP;
  logic              abnormalityQ;
  logic [N_CH-1:0]   alarm;
  logic              busy;

  modport master (
    output chReq, chPH, alarmClear,
    input  chGrant, sampleValid, sampleCh, samplePH,
           abnormalityP, abnormalityQ, alarm, busy
  );

  modport slave (
    input  chReq, chPH, alarmClear,
    output chGrant, sampleValid, sampleCh, samplePH,
           abnormalityP, abnormalityQ, alarm, busy
  );
endinterface

// File: rtl/ph_sample_scheduler.sv
// Round-robin blood-PH sampling scheduler. Grants one sensor channel at a time,
// captures its 4-bit PH, classifies it (P: not 7/8, Q: outside 6..9), tracks
// consecutive P-abnormal samples per channel and raises per-channel alarms.
// Build option: define PH_ALARM_LATCH_EN to make alarms sticky until
// alarmClear or rst; otherwise each REPORT recomputes its channel's alarm.
module ph_sample_scheduler #(
  parameter int N_CH      = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 3,
  parameter int ALARM_CNT = 3
) (
  input logic clk,
  input logic rst,
  ph_sample_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, CAPTURE, REPORT} stateT;

  stateT            state, stateNext;
  logic [CH_W-1:0]  rrPtr;
  logic [CH_W-1:0]  selCh;
  logic [CH_W-1:0]  pickCh;
  logic [CH_W-1:0]  cand;
  logic             pickFound;
  logic [3:0]       phSel;
  logic             capP, capQ;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] curCnt, repCnt;
  logic             repSet;

  // Round-robin pick: first requester after rrPtr, wrapping around.
  always_comb begin
    pickFound = 1'b0;
    pickCh    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= unsigned'(N_CH); k++) begin
      cand = CH_W'((k + rrPtr) % N_CH);
      if (!pickFound && bus.chReq[cand]) begin
        pickFound = 1'b1;
        pickCh    = cand;
      end
    end
  end

  // Next-state sequencing IDLE -> GRANT -> CAPTURE -> REPORT -> IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pickFound) stateNext = GRANT;
      GRANT:   stateNext = CAPTURE;
      CAPTURE: stateNext = REPORT;
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Selected channel's PH and counter, classification and run/alarm update values.
  always_comb begin
    phSel  = '0;
    curCnt = '0;
    for (int unsigned i = 0; i < unsigned'(N_CH); i++) begin
      if (selCh == CH_W'(i)) begin
        phSel  = bus.chPH[4*i +: 4];
        curCnt = cnt[i];
      end
    end
    capP = !((phSel == 4'd7) || (phSel == 4'd8));
    capQ = (phSel < 4'd6) || (phSel > 4'd9);
    if (!bus.abnormalityP)  repCnt = '0;
    else if (curCnt == '1)  repCnt = curCnt;
    else                    repCnt = curCnt + 1'b1;
    repSet = bus.abnormalityQ || (repCnt >= CNT_W'(ALARM_CNT));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Registered grant, pointer and sample-report outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr            <= CH_W'(N_CH - 1);
      selCh            <= '0;
      bus.chGrant      <= '0;
      bus.sampleValid  <= 1'b0;
      bus.sampleCh     <= '0;
      bus.samplePH     <= '0;
      bus.abnormalityP <= 1'b0;
      bus.abnormalityQ <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.chGrant     <= '0;
      bus.sampleValid <= 1'b0;
      bus.busy        <= (stateNext != IDLE);
      case (state)
        IDLE: if (pickFound) begin
          selCh       <= pickCh;
          bus.chGrant <= N_CH'(1) << pickCh;
        end
        GRANT: rrPtr <= selCh;
        CAPTURE: begin
          bus.sampleValid  <= 1'b1;
          bus.sampleCh     <= selCh;
          bus.samplePH     <= phSel;
          bus.abnormalityP <= capP;
          bus.abnormalityQ <= capQ;
        end
        default: ;
      endcase
    end
  end

  // Per-channel abnormal-run counters and alarms; a REPORT that sets an alarm
  // overrides a same-cycle clear, otherwise the clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alarm <= '0;
      for (int unsigned i = 0; i < unsigned'(N_CH); i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < unsigned'(N_CH); i++) begin
        if (state == REPORT && selCh == CH_W'(i) && repSet) begin
          cnt[i]       <= repCnt;
          bus.alarm[i] <= 1'b1;
        end else if (bus.alarmClear[i]) begin
          cnt[i]       <= '0;
          bus.alarm[i] <= 1'b0;
        end else if (state == REPORT && selCh == CH_W'(i)) begin
          cnt[i]       <= repCnt;
`ifdef PH_ALARM_LATCH_EN
          bus.alarm[i] <= bus.alarm[i];
`else
          bus.alarm[i] <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ph_sample_scheduler.sv
// Self-checking bench for ph_sample_scheduler: scoreboard of expected sample
// reports plus per-scenario checks of grants, latency, alarms and reset.
module tb_ph_sample_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef PH_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  ph_sample_scheduler_if #(.N_CH(4), .CH_W(2)) bus ();

  ph_sample_scheduler #(.N_CH(4), .CH_W(2), .CNT_W(3), .ALARM_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] ph;
    logic       p;
    logic       q;
  } sample_t;

  sample_t sbq[$];
  int nCmp = 0;
  int nErr = 0;

  task automatic clearInputs();
    bus.chReq      = '0;
    bus.chPH       = '0;
    bus.alarmClear = '0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    clearInputs();
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive one request, release it at grant, return the report (bounded wait).
  task automatic runOne(input int ch, input logic [3:0] ph, input logic p, input logic q,
                        output bit ok, output sample_t obs);
    sample_t e;
    e.ch = 2'(ch); e.ph = ph; e.p = p; e.q = q;
    sbq.push_back(e);
    bus.chPH[4*ch +: 4] = ph;
    bus.chReq[ch]       = 1'b1;
    ok  = 1'b0;
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.chGrant != '0) bus.chReq[ch] = 1'b0;
      if (bus.sampleValid) begin
        ok  = 1'b1;
        obs = {bus.sampleCh, bus.samplePH, bus.abnormalityP, bus.abnormalityQ};
        break;
      end
    end
    bus.chReq[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.chGrant, bus.sampleValid, bus.sampleCh, bus.samplePH,
            bus.abnormalityP, bus.abnormalityQ, bus.alarm, bus.busy};
    nCmp++;
    if (outs !== 18'd0) begin
      nErr++; $display("FAIL reset_outputs got %h want %h", outs, 18'd0);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nCmp++;
    if (bus.busy !== 1'b0 || bus.chGrant !== 4'b0000) begin
      nErr++; $display("FAIL idle_no_req got busy=%b grant=%b want busy=0 grant=0000", bus.busy, bus.chGrant);
    end
  endtask

  task automatic test_single();
    sample_t e, obs;
    bus.chPH[3:0] = 4'd7;
    bus.chReq     = 4'b0001;
    e.ch = 2'd0; e.ph = 4'd7; e.p = 1'b0; e.q = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    nCmp++;
    if (bus.chGrant !== 4'b0001 || bus.busy !== 1'b1) begin
      nErr++; $display("FAIL t1_grant got grant=%b busy=%b want 0001 busy=1", bus.chGrant, bus.busy);
    end
    bus.chReq = '0;
    @(posedge clk); #1;
    nCmp++;
    if (bus.chGrant !== 4'b0000 || bus.sampleValid !== 1'b0) begin
      nErr++; $display("FAIL t1_grant_once got grant=%b valid=%b want 0000 valid=0", bus.chGrant, bus.sampleValid);
    end
    @(posedge clk); #1;
    nCmp++;
    if (bus.sampleValid !== 1'b1) begin
      nErr++; $display("FAIL t1_latency got valid=%b want 1", bus.sampleValid);
    end
    obs = {bus.sampleCh, bus.samplePH, bus.abnormalityP, bus.abnormalityQ};
    e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
    nCmp++;
    if (obs !== e) begin
      nErr++; $display("FAIL t1_sample got %h want %h", obs, e);
    end
    @(posedge clk); #1;
    nCmp++;
    if (bus.sampleValid !== 1'b0 || bus.samplePH !== 4'd7 || bus.alarm !== 4'b0000 || bus.busy !== 1'b0) begin
      nErr++; $display("FAIL t1_after got valid=%b ph=%0d alarm=%b busy=%b want 0 7 0000 0",
                       bus.sampleValid, bus.samplePH, bus.alarm, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expG [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         expGap [5] = '{1, 2, 2, 2, 2};
    int         gap;
    sample_t    e, obs;
    applyReset();
    bus.chPH  = 16'h8888;
    bus.chReq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e.ch = 2'(k % 4); e.ph = 4'd8; e.p = 1'b0; e.q = 1'b0;
      sbq.push_back(e);
      gap = 0;
      do begin
        @(posedge clk); #1;
        gap++;
      end while (bus.chGrant == '0 && gap < 10);
      nCmp++;
      if (bus.chGrant !== expG[k] || gap != expGap[k]) begin
        nErr++; $display("FAIL t2_grant%0d got %b after %0d cycles want %b after %0d",
                         k, bus.chGrant, gap, expG[k], expGap[k]);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (k == 4) bus.chReq = '0;
      obs = {bus.sampleCh, bus.samplePH, bus.abnormalityP, bus.abnormalityQ};
      e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
      nCmp++;
      if (bus.sampleValid !== 1'b1 || obs !== e) begin
        nErr++; $display("FAIL t2_sample%0d got valid=%b %h want valid=1 %h", k, bus.sampleValid, obs, e);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if (bus.alarm !== 4'b0000 || bus.busy !== 1'b0) begin
      nErr++; $display("FAIL t2_idle got alarm=%b busy=%b want 0000 0", bus.alarm, bus.busy);
    end
  endtask

  task automatic test_persistent();
    bit ok;
    sample_t obs, e;
    for (int r = 0; r < 4; r++) begin
      if (r < 3) runOne(2, 4'd9, 1'b1, 1'b0, ok, obs);
      else       runOne(2, 4'd8, 1'b0, 1'b0, ok, obs);
      e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
      nCmp++;
      if (!ok || obs !== e) begin
        nErr++; $display("FAIL t3_sample%0d got ok=%b %h want %h", r, ok, obs, e);
      end
      @(posedge clk); #1;
      nCmp++;
      if (bus.alarm[2] !== ((r == 2) || (r == 3 && LATCH))) begin
        nErr++; $display("FAIL t3_alarm%0d got %b want %b", r, bus.alarm[2], ((r == 2) || (r == 3 && LATCH)));
      end
    end
  endtask

  task automatic test_q_alarm();
    bit ok;
    sample_t obs, e;
    runOne(1, 4'd3, 1'b1, 1'b1, ok, obs);
    e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
    nCmp++;
    if (!ok || obs !== e) begin
      nErr++; $display("FAIL t4_sample got ok=%b %h want %h", ok, obs, e);
    end
    @(posedge clk); #1;
    nCmp++;
    if (bus.alarm[1] !== 1'b1) begin
      nErr++; $display("FAIL t4_alarm_set got %b want 1", bus.alarm[1]);
    end
    bus.alarmClear[1] = 1'b1;
    @(posedge clk); #1;
    bus.alarmClear[1] = 1'b0;
    nCmp++;
    if (bus.alarm[1] !== 1'b0) begin
      nErr++; $display("FAIL t4_alarm_clear got %b want 0", bus.alarm[1]);
    end
    for (int r = 0; r < 2; r++) begin
      runOne(1, 4'd9, 1'b1, 1'b0, ok, obs);
      e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
      @(posedge clk); #1;
      nCmp++;
      if (!ok || obs !== e || bus.alarm[1] !== 1'b0) begin
        nErr++; $display("FAIL t4_cnt_cleared%0d got ok=%b %h alarm=%b want %h alarm=0", r, ok, obs, bus.alarm[1], e);
      end
    end
  endtask

  task automatic test_clear_collision();
    bit ok;
    sample_t obs, e;
    bus.alarmClear[2] = 1'b1;
    @(posedge clk); #1;
    bus.alarmClear[2] = 1'b0;
    nCmp++;
    if (bus.alarm[2] !== 1'b0) begin
      nErr++; $display("FAIL t5_preclear got %b want 0", bus.alarm[2]);
    end
    runOne(2, 4'd2, 1'b1, 1'b1, ok, obs);
    bus.alarmClear[2] = 1'b1;
    @(posedge clk); #1;
    bus.alarmClear[2] = 1'b0;
    e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
    nCmp++;
    if (!ok || obs !== e) begin
      nErr++; $display("FAIL t5_sample got ok=%b %h want %h", ok, obs, e);
    end
    nCmp++;
    if (bus.alarm[2] !== 1'b1) begin
      nErr++; $display("FAIL t5_set_wins got %b want 1", bus.alarm[2]);
    end
    for (int r = 0; r < 2; r++) begin
      runOne(2, 4'd9, 1'b1, 1'b0, ok, obs);
      e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
      @(posedge clk); #1;
      nCmp++;
      if (!ok || obs !== e || bus.alarm[2] !== ((r == 1) || LATCH)) begin
        nErr++; $display("FAIL t5_cnt_kept%0d got ok=%b %h alarm=%b want %h alarm=%b",
                         r, ok, obs, bus.alarm[2], e, ((r == 1) || LATCH));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] outs;
    bit ok;
    sample_t obs, e;
    bus.chPH[7:4] = 4'd5;
    bus.chReq     = 4'b0010;
    @(posedge clk); #1;
    bus.chReq = '0;
    nCmp++;
    if (bus.chGrant !== 4'b0010) begin
      nErr++; $display("FAIL t6_pre_grant got %b want 0010", bus.chGrant);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    outs = {bus.chGrant, bus.sampleValid, bus.sampleCh, bus.samplePH,
            bus.abnormalityP, bus.abnormalityQ, bus.alarm, bus.busy};
    nCmp++;
    if (outs !== 18'd0) begin
      nErr++; $display("FAIL t6_async_reset got %h want %h", outs, 18'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.chPH = 16'h0666;
    e.ch = 2'd0; e.ph = 4'd6; e.p = 1'b1; e.q = 1'b0;
    sbq.push_back(e);
    bus.chReq = 4'b0111;
    @(posedge clk); #1;
    bus.chReq = '0;
    nCmp++;
    if (bus.chGrant !== 4'b0001 || bus.sampleValid !== 1'b0) begin
      nErr++; $display("FAIL t6_first_grant got %b valid=%b want 0001 valid=0", bus.chGrant, bus.sampleValid);
    end
    ok = 1'b0;
    obs = '0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.sampleValid) begin
        ok  = 1'b1;
        obs = {bus.sampleCh, bus.samplePH, bus.abnormalityP, bus.abnormalityQ};
      end
    end
    e = (sbq.size() != 0) ? sbq.pop_front() : sample_t'('1);
    nCmp++;
    if (!ok || obs !== e) begin
      nErr++; $display("FAIL t6_sample got ok=%b %h want %h", ok, obs, e);
    end
    nCmp++;
    if (sbq.size() != 0) begin
      nErr++; $display("FAIL scoreboard_empty got %0d left want 0", sbq.size());
    end
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_single();
    test_round_robin();
    test_persistent();
    test_q_alarm();
    test_clear_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
